fetch_stall_ctrl: RTL
=====================

# fetch_stall_ctrl

Owns the program counter, the dual-issue IF/ID pipeline register and the ID/EX control-bubble register, and applies the stall/bubble requests raised by the hazard detection unit (PCWrite, IF_ID_Write, CntrlSel) together with ID-stage branch redirects. It sits between instruction memory and the ID stage.

## Interface
Parameters:
- PC_W, 8, PC and branch-target width
- INST_W, 16, width of each fetched instruction
- CTRL_W, 8, width of the decoded control bundle passed to ID/EX
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- PCWrite  in  1  1 = PC may update this cycle
- IF_ID_Write  in  1  1 = IF/ID may load this cycle
- CntrlSel  in  1  1 = insert bubble into ID/EX control
- BranchTaken  in  1  ID-stage branch resolved taken
- BranchTarget  in  PC_W  redirect address
- imem_inst1  in  INST_W  instruction at PC (combinational memory read)
- imem_inst2  in  INST_W  instruction at PC+1
- ID_ctrl  in  CTRL_W  decoder control for current IF/ID pair
- PC  out  PC_W  fetch address
- IF_ID_inst1, IF_ID_inst2  out  INST_W  latched instruction pair
- IF_ID_PC  out  PC_W  PC of IF_ID_inst1
- IF_ID_Valid  out  1  IF/ID holds real instructions
- ID_EX_ctrl  out  CTRL_W  registered control to EX
- ID_EX_Valid  out  1  ID/EX holds a real instruction pair
- fetch_state  out  2  FSM state: 0 BOOT, 1 RUN, 2 STALL, 3 FLUSH
- stall_cnt  out  16  stall-cycle count (only with STALL_CNT_EN)

## Operation
- Reset (rst_n=0, immediate): PC=RESET_PC, IF_ID_inst1/2=0, IF_ID_PC=0, IF_ID_Valid=0, ID_EX_ctrl=0, ID_EX_Valid=0, fetch_state=BOOT, stall_cnt=0.
- BOOT: exactly one cycle after rst_n rises; PC, IF/ID, ID/EX are held (no fetch latched); next state RUN.
- PC update (non-BOOT), priority: PCWrite=0 -> hold; PCWrite=1 & BranchTaken=1 -> PC=BranchTarget; else PC=PC+2, modulo 2^PC_W (wraps from 2^PC_W-2 to 0, from 2^PC_W-1 to 1).
- IF/ID update (non-BOOT), priority: PCWrite=1 & BranchTaken=1 -> flush: insts=0, IF_ID_Valid=0 (IF_ID_PC unchanged); else IF_ID_Write=1 -> load imem_inst1/2, IF_ID_PC=PC, IF_ID_Valid=1; else hold.
- BranchTaken with PCWrite=0 is ignored that cycle; IF/ID holds the branch, which is re-presented next cycle.
- PCWrite and IF_ID_Write are honoured independently; PCWrite=1 with IF_ID_Write=0 advances PC and drops the fetched pair (legal, caller's responsibility).
- ID/EX (non-BOOT): CntrlSel=1 or IF_ID_Valid=0 -> ID_EX_ctrl=0, ID_EX_Valid=0; else ID_EX_ctrl=ID_ctrl, ID_EX_Valid=1. In BOOT, ID/EX is forced to 0/0.
- FSM transitions, evaluated at each edge from non-BOOT states: PCWrite=1 & BranchTaken=1 -> FLUSH; PCWrite=0 -> STALL; else RUN. FLUSH lasts one cycle unless re-entered.

## Timing
- All outputs registered; no combinational input-to-output path.
- Fetch latency: the pair at PC appears on IF_ID_* one edge after PC presents it; ID/EX control follows one edge later.
- Branch penalty: redirect edge loads target and bubbles IF/ID; target pair is in IF/ID two edges after BranchTaken is sampled.
- Stall: every cycle with PCWrite=0 holds PC exactly; on release, PC advances on the first edge with PCWrite=1.
- Asserting rst_n=0 mid-stall or mid-flush returns every output to its reset value immediately; restart always passes through BOOT.

## Configuration
- STALL_CNT_EN defined: 16-bit stall_cnt increments at each edge where fetch_state is not BOOT and PCWrite=0; saturates at 0xFFFF; cleared only by reset.
- STALL_CNT_EN undefined: stall_cnt port and counter are absent; all other behaviour identical.

## Test plan
- Reset release, PCWrite=IF_ID_Write=1, CntrlSel=0, imem=0x1111/0x2222 -> BOOT one cycle with PC=0, then PC 0->2->4; IF_ID_PC=0, IF_ID_Valid=1 one edge after RUN.
- PCWrite=IF_ID_Write=0 for 3 cycles at PC=6 -> PC stays 6, IF/ID unchanged, fetch_state=STALL; stall_cnt=3 with STALL_CNT_EN.
- BranchTaken=1, BranchTarget=0x40, PCWrite=1 -> PC=0x40, IF_ID_Valid=0, fetch_state=FLUSH one cycle; next edge IF_ID_PC=0x40.
- BranchTaken=1 with PCWrite=0 -> no redirect; release PCWrite next cycle with BranchTaken=1 -> redirect then.
- CntrlSel=1 with valid IF/ID, ID_ctrl=0xA5 -> ID_EX_ctrl=0, ID_EX_Valid=0; CntrlSel=0 -> ID_EX_ctrl=0xA5.
- PC_W=8, PC=0xFE, PCWrite=1 -> PC=0x00; rst_n pulse low mid-stall -> all outputs reset asynchronously, BOOT on release.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side pipeline control: PC, dual-issue IF/ID register and ID/EX control bubble,
// driven by hazard-unit stall requests and ID-stage branch redirects. Optional STALL_CNT_EN adds a stall counter.
module fetch_stall_ctrl #(
    parameter int PC_W     = 8,
    parameter int INST_W   = 16,
    parameter int CTRL_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              CntrlSel,
    input  logic              BranchTaken,
    input  logic [PC_W-1:0]   BranchTarget,
    input  logic [INST_W-1:0] imem_inst1,
    input  logic [INST_W-1:0] imem_inst2,
    input  logic [CTRL_W-1:0] ID_ctrl,
    output logic [PC_W-1:0]   PC,
    output logic [INST_W-1:0] IF_ID_inst1,
    output logic [INST_W-1:0] IF_ID_inst2,
    output logic [PC_W-1:0]   IF_ID_PC,
    output logic              IF_ID_Valid,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              ID_EX_Valid,
    output logic [1:0]        fetch_state
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [INST_W-1:0]   r_if_inst1;
    logic [INST_W-1:0]   r_if_inst2;
    logic [PC_W-1:0]     r_if_pc;
    logic                r_if_valid;
    logic [CTRL_W-1:0]   r_ex_ctrl;
    logic                r_ex_valid;
    logic                w_boot;
    logic                w_redirect;

    assign w_boot     = (r_state == ST_BOOT);
    // A taken branch only counts when the PC is allowed to move.
    assign w_redirect = PCWrite & BranchTaken;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = ST_RUN;
        if (!w_boot) begin
            if (w_redirect)
                w_state_nxt = ST_FLUSH;
            else if (!PCWrite)
                w_state_nxt = ST_STALL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_W'(RESET_PC);
        end else if (!w_boot && PCWrite) begin
            if (BranchTaken)
                r_pc <= BranchTarget;
            else
                r_pc <= r_pc + PC_W'(2);
        end
    end

    // Redirect flushes the wrong-path pair but keeps IF_ID_PC as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_inst1 <= '0;
            r_if_inst2 <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (!w_boot) begin
            if (w_redirect) begin
                r_if_inst1 <= '0;
                r_if_inst2 <= '0;
                r_if_valid <= 1'b0;
            end else if (IF_ID_Write) begin
                r_if_inst1 <= imem_inst1;
                r_if_inst2 <= imem_inst2;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl  <= '0;
            r_ex_valid <= 1'b0;
        end else if (w_boot || CntrlSel || !r_if_valid) begin
            r_ex_ctrl  <= '0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_ctrl  <= ID_ctrl;
            r_ex_valid <= 1'b1;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!w_boot && !PCWrite && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign PC          = r_pc;
    assign IF_ID_inst1 = r_if_inst1;
    assign IF_ID_inst2 = r_if_inst2;
    assign IF_ID_PC    = r_if_pc;
    assign IF_ID_Valid = r_if_valid;
    assign ID_EX_ctrl  = r_ex_ctrl;
    assign ID_EX_Valid = r_ex_valid;
    assign fetch_state = r_state;

endmodule
